zuart_tx_frame: RTL and testbench

Parametrised UART transmitter. Successor to the fixed 8N1-style TX step machine. Adds:
- configurable data width;
- runtime-selectable parity (none/even/odd/mark) and 1 or 2 stop bits;
- an internal baud divider, so no external bps tick is needed;
- a valid/ready input handshake with per-frame configuration latching.

It sits between the command/telemetry packer and the board TX pin of the photon-detector controller.

---
 rtl/zuart_pkg.sv | 27 ++
 rtl/zuart_baud_gen.sv | 45 ++++
 rtl/zuart_tx_frame.sv | 176 +++++++++++++++++
 tb/tb_zuart_tx_frame.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zuart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zuart_pkg
// Purpose  : Definitions shared by the zuart frame transmitter and the future
//            zuart_rx_frame receiver: parity-mode codes and the frame FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package zuart_pkg;

  // Parity select codes carried on parity_mode.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  // Frame state machine encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

endpackage : zuart_pkg
`default_nettype wire

// File: rtl/zuart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : zuart_baud_gen
// Purpose  : Bit-period divider. Counts 0..div and raises bit_tick while the
//            count equals div; the count then wraps to 0. restart clears the
//            count synchronously so a new frame starts on a full bit period.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            restart  - synchronous clear of the period counter
//            div      - bit period minus one, in clk cycles
//            bit_tick - last cycle of the current bit period
// Revision : 1.0 - initial release
// ============================================================================
module zuart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    bit_tick = (cnt_q == div);
    if (restart || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : zuart_baud_gen
`default_nettype wire

// File: rtl/zuart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : zuart_tx_frame
// Purpose  : Parametrised UART transmitter. Accepts a frame on a valid/ready
//            handshake, latches data and line configuration, and serialises
//            start, DATA_BITS data bits (LSB first), optional parity and one
//            or two stop bits, each held clk_div+1 cycles.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            clk_div             - bit period minus one (latched at accept)
//            parity_mode         - none/even/odd/mark (latched at accept)
//            stop2               - two stop bits when set (latched at accept)
//            tx_valid, tx_data   - frame offer
//            tx_ready            - high only while idle
//            tx_pin              - registered serial line, idles high
//            busy                - frame in progress on the line
//            done                - one-cycle pulse in the first idle cycle
// Revision : 1.0 - initial release
// ============================================================================
module zuart_tx_frame
  import zuart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_pin,
  output logic                 busy,
  output logic                 done
);

  localparam int              CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 stop2_q, stop2_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic accept;
  logic bit_tick;

  assign tx_ready = (state_q == ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign tx_pin   = tx_pin_q;
  assign busy     = busy_q;
  assign done     = done_q;

  zuart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          div_d      = clk_div;
          par_mode_d = parity_mode;
          stop2_d    = stop2;
          // Seeding with 1 for odd parity lets one XOR chain serve both modes.
          par_d      = (parity_mode == PAR_ODD);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (par_mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == stop2_q) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line flop is loaded from the next state so the pin changes on the
    // same edge the FSM moves, keeping the pin registered without a lag.
    case (state_d)
      ST_START:  tx_pin_d = 1'b0;
      ST_DATA:   tx_pin_d = shift_d[0];
      ST_PARITY: tx_pin_d = (par_mode_d == PAR_MARK) ? 1'b1 : par_d;
      default:   tx_pin_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_pin_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_pin_q   <= tx_pin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule : zuart_tx_frame
`default_nettype wire

// File: tb/tb_zuart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_zuart_tx_frame
// Purpose  : Self-checking bench for zuart_tx_frame (DATA_BITS=8 instance plus
//            a DATA_BITS=5 instance). Expected line waveforms are built from
//            the frame rules as a list of bit levels repeated per bit period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zuart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] clk_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, tx_pin, busy, done;

  logic [15:0] t5_div;
  logic [1:0]  t5_par;
  logic        t5_stop2;
  logic        t5_valid;
  logic [4:0]  t5_data;
  logic        t5_ready, t5_pin, t5_busy, t5_done;

  zuart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_div     (clk_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_pin      (tx_pin),
    .busy        (busy),
    .done        (done)
  );

  zuart_tx_frame #(.DATA_BITS(5), .DIV_W(16)) u_dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_div     (t5_div),
    .parity_mode (t5_par),
    .stop2       (t5_stop2),
    .tx_valid    (t5_valid),
    .tx_data     (t5_data),
    .tx_ready    (t5_ready),
    .tx_pin      (t5_pin),
    .busy        (t5_busy),
    .done        (t5_done)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit cap_q[$];

  typedef struct {
    logic [7:0] data;
    int         div;
    int         par;
    int         s2;
    int         exp_len;
    bit         exp_par;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference frame: list of bit levels, each repeated (div+1) cycles.
  function automatic void build_frame(input logic [8:0] d, input int nbits,
                                      input int par, input int s2, input int div);
    int ones = 0;
    bit bits[$];
    exp_q.delete();
    bits.push_back(1'b0);
    for (int k = 0; k < nbits; k++) begin
      bits.push_back(d[k]);
      if (d[k]) ones++;
    end
    if (par == 1)      bits.push_back(bit'(ones % 2));
    else if (par == 2) bits.push_back(bit'(1 - (ones % 2)));
    else if (par == 3) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (s2 != 0) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int r = 0; r <= div; r++) exp_q.push_back(bits[i]);
    end
  endfunction

  task automatic compare_frame(input string name);
    int bad = 0;
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (cap_q[i] != exp_q[i]) bad++;
    end
    check({name, "_len"}, cap_q.size(), exp_q.size());
    check({name, "_bad_bits"}, bad, 0);
  endtask

  // Records the line from the cycle after accept until done is seen.
  task automatic capture(output int len);
    bit busy_ok = 1'b1;
    bit got_done = 1'b0;
    len = 0;
    cap_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      cap_q.push_back(tx_pin);
      if (busy !== 1'b1) busy_ok = 1'b0;
      len++;
    end
    check("done_seen", got_done, 1);
    check("busy_in_frame", busy_ok, 1);
    check("done_cycle_busy_ready_pin", {busy, tx_ready, tx_pin}, 3'b011);
  endtask

  task automatic offer(input logic [7:0] d, input int div, input int par, input int s2);
    int w = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", tx_ready, 1);
    tx_data     = d;
    clk_div     = div[15:0];
    parity_mode = par[1:0];
    stop2       = s2[0];
    tx_valid    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // After accept every input is changed to show the frame uses latched values.
  task automatic scramble();
    tx_valid    = 1'b0;
    tx_data     = 8'($urandom);
    clk_div     = 16'($urandom_range(0, 7));
    parity_mode = 2'($urandom);
    stop2       = 1'($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int pidx;
    bit done_seen;
    logic [7:0] rd;
    int rdiv, rpar, rs2;

    vecs[0] = '{8'hA5, 3, 0, 0, 40, 1'b0};
    vecs[1] = '{8'hA5, 3, 1, 0, 44, 1'b0};
    vecs[2] = '{8'hA5, 3, 2, 0, 44, 1'b1};
    vecs[3] = '{8'hA5, 3, 3, 0, 44, 1'b1};
    vecs[4] = '{8'h00, 0, 0, 1, 11, 1'b0};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; clk_div = '0;
    parity_mode = '0; stop2 = 1'b0;
    t5_valid = 1'b0; t5_data = '0; t5_div = '0; t5_par = '0; t5_stop2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_pin", tx_pin, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pin5", t5_pin, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    check("done_after_reset", done, 0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i].data, vecs[i].div, vecs[i].par, vecs[i].s2);
      scramble();
      capture(len);
      check("vec_frame_len", len, vecs[i].exp_len);
      if (vecs[i].par != 0) begin
        pidx = 9 * (vecs[i].div + 1);
        if (pidx < cap_q.size()) check("vec_parity_bit", cap_q[pidx], vecs[i].exp_par);
        else check("vec_parity_present", 0, 1);
      end
      build_frame({1'b0, vecs[i].data}, 8, vecs[i].par, vecs[i].s2, vecs[i].div);
      compare_frame("vec_line");
    end

    // Randomised frames against the reference model
    for (int i = 0; i < 30; i++) begin
      rd   = 8'($urandom);
      rdiv = $urandom_range(0, 5);
      rpar = $urandom_range(0, 3);
      rs2  = $urandom_range(0, 1);
      offer(rd, rdiv, rpar, rs2);
      scramble();
      capture(len);
      build_frame({1'b0, rd}, 8, rpar, rs2, rdiv);
      compare_frame("rand_line");
    end

    // Back-to-back with tx_valid held; clk_div changed during the first frame
    offer(8'h01, 3, 0, 0);
    tx_data = 8'h80;
    clk_div = 16'd2;
    capture(len);
    check("b2b_first_len", len, 40);
    build_frame(9'h001, 8, 0, 0, 3);
    compare_frame("b2b_first");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    capture(len);
    build_frame(9'h080, 8, 0, 0, 2);
    compare_frame("b2b_second");

    // Reset during data bit 4
    offer(8'hA5, 3, 0, 0);
    scramble();
    repeat (22) @(negedge clk);
    check("pre_reset_bit4", tx_pin, 0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_pin", tx_pin, 1);
    check("reset_mid_busy", busy, 0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) done_seen = 1'b1;
    check("reset_mid_no_done", done_seen, 0);
    check("reset_mid_ready", tx_ready, 1);
    offer(8'h3C, 2, 1, 1);
    scramble();
    capture(len);
    build_frame(9'h03C, 8, 1, 1, 2);
    compare_frame("after_reset");

    // DATA_BITS=5 instance, odd parity
    @(negedge clk);
    check("d5_ready", t5_ready, 1);
    t5_data = 5'b10110; t5_div = 16'd1; t5_par = 2'd2; t5_stop2 = 1'b0; t5_valid = 1'b1;
    @(posedge clk);
    #1;
    t5_valid = 1'b0; t5_data = 5'h1F; t5_div = 16'd7; t5_par = 2'd0;
    cap_q.delete();
    done_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (t5_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      cap_q.push_back(t5_pin);
    end
    check("d5_done_seen", done_seen, 1);
    check("d5_frame_len", cap_q.size(), 16);
    if (cap_q.size() > 12) check("d5_parity_bit", cap_q[12], 0);
    build_frame(9'b0_0001_0110, 5, 2, 0, 1);
    compare_frame("d5_line");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_zuart_tx_frame
`default_nettype wire
